// File: rtl/matrix_dma_arbiter.sv
// Round-robin arbiter that shares one Wishbone-classic master port between
// NUM_REQ DMA requesters, with grants capped at BURST_MAX beats.
module matrix_dma_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BURST_MAX = 8,
  parameter int IDX_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [32*NUM_REQ-1:0]  addr_i,
  input  logic [32*NUM_REQ-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [31:0]            rdata_o,
  output logic                   mem_stb_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_adr_o,
  output logic [31:0]            mem_dat_o,
  input  logic [31:0]            mem_dat_i,
  input  logic                   mem_ack_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
);

  typedef enum logic {ST_ARB, ST_XFER} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  int                   cand;
  logic                 cur_req;

  // Rotating priority: first requester after the previous owner wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_idx_q) + i) % NUM_REQ;
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // Master-port mux; everything is zero unless a grant is held.
  always_comb begin
    mem_stb_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = 32'h0;
    mem_dat_o = 32'h0;
    ack_o     = '0;
    cur_req   = 1'b0;
    if (state_q == ST_XFER) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt_idx_q == IDX_W'(k)) begin
          cur_req   = req_i[k];
          mem_stb_o = req_i[k];
          mem_we_o  = we_i[k];
          mem_adr_o = addr_i[32*k +: 32];
          mem_dat_o = wdata_i[32*k +: 32];
          ack_o[k]  = mem_ack_i;
        end
      end
    end
  end

  assign rdata_o = mem_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_XFER);

  // Next-state logic for the grant FSM.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    case (state_q)
      ST_ARB: begin
        if (pick_vld) begin
          gnt_idx_d  = pick_idx;
          beat_cnt_d = 8'd0;
          state_d    = ST_XFER;
          for (int k = 0; k < NUM_REQ; k++) begin
            grant_d[k] = (pick_idx == IDX_W'(k));
          end
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_XFER: begin
        if (mem_ack_i) begin
          if (beat_cnt_q == 8'(BURST_MAX - 1)) begin
            last_idx_d = gnt_idx_q;
            grant_d    = '0;
            state_d    = ST_ARB;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else if (!cur_req) begin
          last_idx_d = gnt_idx_q;
          grant_d    = '0;
          state_d    = ST_ARB;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last_idx resets to the top port so port 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      gnt_idx_q  <= '0;
      last_idx_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= 8'd0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

endmodule

// File: tb/tb_matrix_dma_arbiter.sv
// Directed bench for matrix_dma_arbiter: two instances (BURST_MAX 4 and 8)
// share requester stimulus; each has its own memory acknowledge.
module tb_matrix_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [31:0] mem_dat_i;
  logic        zero_wait, man_ack;

  logic [1:0]  ack4, grant4, ack8, grant8;
  logic [31:0] rdata4, adr4, dat4, rdata8, adr8, dat8;
  logic        stb4, we4, busy4, stb8, we8, busy8;
  logic        mack4, mack8;

  int passed = 0;
  int total  = 0;
  int acks   = 0;
  int gaps   = 0;
  logic [1:0] exp_g;

  always #5 clk = ~clk;

  // Zero-wait memory acknowledges whatever strobe is presented.
  assign mack4 = zero_wait ? stb4 : man_ack;
  assign mack8 = zero_wait ? stb8 : man_ack;

  matrix_dma_arbiter #(.NUM_REQ(2), .BURST_MAX(4), .IDX_W(3)) u_dut4 (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack4), .rdata_o(rdata4), .mem_stb_o(stb4),
    .mem_we_o(we4), .mem_adr_o(adr4), .mem_dat_o(dat4), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mack4), .grant_o(grant4), .busy_o(busy4));

  matrix_dma_arbiter #(.NUM_REQ(2), .BURST_MAX(8), .IDX_W(3)) u_dut8 (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack8), .rdata_o(rdata8), .mem_stb_o(stb8),
    .mem_we_o(we8), .mem_adr_o(adr8), .mem_dat_o(dat8), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mack8), .grant_o(grant8), .busy_o(busy8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    req_i     = 2'b00;
    we_i      = 2'b00;
    man_ack   = 1'b0;
    zero_wait = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    chk("rst_stb",   32'(stb8),   32'd0);
    chk("rst_grant", 32'(grant8), 32'd0);
    chk("rst_busy",  32'(busy8),  32'd0);
    chk("rst_ack",   32'(ack8),   32'd0);
    chk("rst_adr",   adr8,        32'd0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_i    = 64'h0;
    wdata_i   = 64'h0;
    mem_dat_i = 32'h0;

    // Single requester, zero-wait memory, 3 beats.
    do_reset();
    zero_wait = 1'b1;
    addr_i[31:0] = 32'h1000;
    req_i = 2'b01;
    #1;
    chk("t1_stb_c0", 32'(stb8), 32'd0);
    tick();
    chk("t1_grant", 32'(grant8), 32'd1);
    chk("t1_busy",  32'(busy8),  32'd1);
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      addr_i[31:0] = 32'h1000 + 32'(4 * k);
      #1;
      chk("t1_stb", 32'(stb8), 32'd1);
      chk("t1_adr", adr8, 32'h1000 + 32'(4 * k));
      if (ack8 == 2'b01) acks++;
      tick();
    end
    chk("t1_acks", 32'(acks), 32'd3);
    req_i = 2'b00;
    #1;
    chk("t1_stb_off", 32'(stb8), 32'd0);
    chk("t1_ack_off", 32'(ack8), 32'd0);
    tick();
    chk("t1_grant_end", 32'(grant8), 32'd0);
    chk("t1_busy_end",  32'(busy8),  32'd0);

    // Contention with BURST_MAX=4: 01 x4, gap, 10 x4, gap, 01 x4.
    do_reset();
    zero_wait = 1'b1;
    req_i = 2'b11;
    tick();
    for (int c = 0; c < 14; c++) begin
      if (c < 4)       exp_g = 2'b01;
      else if (c == 4) exp_g = 2'b00;
      else if (c < 9)  exp_g = 2'b10;
      else if (c == 9) exp_g = 2'b00;
      else             exp_g = 2'b01;
      chk("t2_grant", 32'(grant4), 32'(exp_g));
      chk("t2_stb",   32'(stb4),   32'(exp_g != 2'b00));
      chk("t2_ack",   32'(ack4),   32'(exp_g));
      tick();
    end
    req_i = 2'b00;
    tick();
    tick();

    // Burst cap with BURST_MAX=8: 20 beats, releases after beats 8 and 16.
    do_reset();
    zero_wait = 1'b1;
    req_i = 2'b01;
    tick();
    acks = 0;
    gaps = 0;
    for (int c = 0; c < 22; c++) begin
      if (ack8 == 2'b01) acks++;
      if (!stb8) gaps++;
      chk("t3_grant", 32'(grant8), (c == 8 || c == 17) ? 32'd0 : 32'd1);
      tick();
    end
    chk("t3_acks", 32'(acks), 32'd20);
    chk("t3_gaps", 32'(gaps), 32'd2);
    req_i = 2'b00;
    tick();
    chk("t3_grant_end", 32'(grant8), 32'd0);

    // Wait-state write from port 1, ack two cycles after strobe.
    do_reset();
    addr_i[63:32]  = 32'h2000;
    wdata_i[63:32] = 32'hDEADBEEF;
    we_i  = 2'b10;
    req_i = 2'b10;
    #1;
    chk("t4_we_idle",  32'(we8), 32'd0);
    chk("t4_adr_idle", adr8,     32'd0);
    tick();
    chk("t4_grant", 32'(grant8), 32'd2);
    chk("t4_we",    32'(we8),    32'd1);
    chk("t4_adr",   adr8,        32'h2000);
    chk("t4_dat0",  dat8,        32'hDEADBEEF);
    chk("t4_ack0",  32'(ack8),   32'd0);
    tick();
    chk("t4_dat1",  dat8,        32'hDEADBEEF);
    chk("t4_ack1",  32'(ack8),   32'd0);
    tick();
    man_ack = 1'b1;
    #1;
    chk("t4_dat2",  dat8,        32'hDEADBEEF);
    chk("t4_ack2",  32'(ack8),   32'd2);
    tick();
    man_ack = 1'b0;
    req_i   = 2'b00;
    we_i    = 2'b00;
    #1;
    chk("t4_ack3",  32'(ack8),   32'd0);
    tick();
    chk("t4_grant_end", 32'(grant8), 32'd0);

    // Spurious ack while idle.
    do_reset();
    mem_dat_i = 32'hA5A5_0F0F;
    man_ack = 1'b1;
    #1;
    chk("t5_ack",   32'(ack8), 32'd0);
    chk("t5_rdata", rdata8,    32'hA5A5_0F0F);
    tick();
    chk("t5_ack_n",  32'(ack8),   32'd0);
    chk("t5_busy",   32'(busy8),  32'd0);
    chk("t5_grant",  32'(grant8), 32'd0);
    man_ack = 1'b0;

    // Reset during beat 2 of port 0, then port 0 wins first again.
    do_reset();
    zero_wait = 1'b1;
    req_i = 2'b01;
    tick();
    chk("t6_grant0", 32'(grant8), 32'd1);
    tick();
    chk("t6_stb_b2", 32'(stb8), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_stb_rst",   32'(stb8),   32'd0);
    chk("t6_grant_rst", 32'(grant8), 32'd0);
    chk("t6_ack_rst",   32'(ack8),   32'd0);
    reset = 1'b0;
    req_i = 2'b11;
    tick();
    chk("t6_grant_after", 32'(grant8), 32'd1);
    req_i = 2'b00;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
